// File: rtl/sha3_sched_pkg.sv
// sha3_sched_pkg: shared types and defaults for the SHA3 job scheduler.
// Revision 1.0
`default_nettype none

package sha3_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_CLEAR = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int LEN_W_DEF  = 16;
    localparam int HASH_W_DEF = 512;
    localparam int TMO_CNT_W  = 21;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after ptr_i, wrapping.
// Revision 1.0
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] grant_o,
    output logic             any_o
);

    always_comb begin
        int idx;
        idx     = 0;
        grant_o = '0;
        any_o   = |req_i;
        // Walk offsets from farthest to nearest so the nearest valid request wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (req_i[IDX_W'(idx)]) begin
                grant_o = IDX_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sha3_job_scheduler.sv
// sha3_job_scheduler: round-robin sharing of one SHA3 engine among N_REQ requesters.
// Revision 1.0
`default_nettype none

module sha3_job_scheduler
    import sha3_sched_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int HASH_W      = HASH_W_DEF,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [N_REQ*LEN_W-1:0]     req_len_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic                       eng_clr_o,
    output logic                       eng_start_o,
    output logic [ADDR_W-1:0]          eng_base_addr_o,
    output logic [LEN_W-1:0]           eng_num_bytes_o,
    input  logic                       eng_out_ready_i,
    input  logic [HASH_W-1:0]          eng_hash_i,
    output logic                       rsp_valid_o,
    output logic [$clog2(N_REQ)-1:0]   rsp_id_o,
    output logic [HASH_W-1:0]          rsp_hash_o,
    output logic                       rsp_err_o,
    input  logic                       rsp_ready_i,
    output logic                       busy_o,
    output logic [15:0]                jobs_done_o
);

    localparam int ID_W = $clog2(N_REQ);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [TMO_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [N_REQ-1:0]       req_ready_q, req_ready_d;
    logic                   eng_clr_q, eng_clr_d;
    logic                   eng_start_q, eng_start_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [LEN_W-1:0]       nbytes_q, nbytes_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [HASH_W-1:0]      rsp_hash_q, rsp_hash_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   busy_q, busy_d;
    logic [15:0]            jobs_done_q, jobs_done_d;

    logic [ID_W-1:0]        w_pick_idx;
    logic                   w_pick_any;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [LEN_W-1:0]       w_sel_len;
    logic                   w_tmo_hit;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (w_pick_idx),
        .any_o   (w_pick_any)
    );

    assign w_sel_addr = req_addr_i[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_len  = req_len_i[w_pick_idx*LEN_W +: LEN_W];
    assign w_tmo_hit  = (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_valid_i) state_d = ST_ARB;
            ST_ARB: begin
                if (!w_pick_any)           state_d = ST_IDLE;
                else if (w_sel_len == '0)  state_d = ST_RESP;
                else                       state_d = ST_CLEAR;
            end
            ST_CLEAR: state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT:  if (eng_out_ready_i || w_tmo_hit) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Next values of the output and capture registers; every port is driven from a flop.
    always_comb begin
        req_ready_d = '0;
        eng_clr_d   = 1'b0;
        eng_start_d = 1'b0;
        base_d      = base_q;
        nbytes_d    = nbytes_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_hash_d  = rsp_hash_q;
        rsp_err_d   = rsp_err_q;
        jobs_done_d = jobs_done_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_ARB: begin
                if (w_pick_any) begin
                    grant_d     = w_pick_idx;
                    req_ready_d = N_REQ'(1) << w_pick_idx;
                    base_d      = w_sel_addr;
                    nbytes_d    = w_sel_len;
                    if (w_sel_len == '0) begin
                        rsp_hash_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        eng_clr_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: eng_start_d = 1'b1;
            ST_START: tmo_cnt_d   = '0;
            ST_WAIT: begin
                // A digest arriving on the expiry cycle still counts as success.
                if (eng_out_ready_i) begin
                    rsp_hash_d = eng_hash_i;
                    rsp_err_d  = 1'b0;
                end else if (w_tmo_hit) begin
                    rsp_hash_d = '0;
                    rsp_err_d  = 1'b1;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d  = tmo_cnt_q + TMO_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rr_ptr_d    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    jobs_done_d = jobs_done_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            req_ready_q <= '0;
            eng_clr_q   <= 1'b0;
            eng_start_q <= 1'b0;
            base_q      <= '0;
            nbytes_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hash_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            req_ready_q <= req_ready_d;
            eng_clr_q   <= eng_clr_d;
            eng_start_q <= eng_start_d;
            base_q      <= base_d;
            nbytes_q    <= nbytes_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hash_q  <= rsp_hash_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign req_ready_o     = req_ready_q;
    assign eng_clr_o       = eng_clr_q;
    assign eng_start_o     = eng_start_q;
    assign eng_base_addr_o = base_q;
    assign eng_num_bytes_o = nbytes_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_id_o        = grant_q;
    assign rsp_hash_o      = rsp_hash_q;
    assign rsp_err_o       = rsp_err_q;
    assign busy_o          = busy_q;
    assign jobs_done_o     = jobs_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sha3_job_scheduler.sv
// tb_sha3_job_scheduler: directed self-checking bench for sha3_job_scheduler.
// Revision 1.0
`default_nettype none

module tb_sha3_job_scheduler;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int LW  = 16;
    localparam int HW  = 512;
    localparam int TMO = 50;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*AW-1:0]  req_addr;
    logic [N*LW-1:0]  req_len;
    logic [N-1:0]     req_ready;
    logic             eng_clr, eng_start;
    logic [AW-1:0]    eng_base_addr;
    logic [LW-1:0]    eng_num_bytes;
    logic             eng_out_ready;
    logic [HW-1:0]    eng_hash;
    logic             rsp_valid;
    logic [1:0]       rsp_id;
    logic [HW-1:0]    rsp_hash;
    logic             rsp_err;
    logic             rsp_ready;
    logic             busy;
    logic [15:0]      jobs_done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_jobs = 0;

    always #5 clk = ~clk;

    sha3_job_scheduler #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .LEN_W       (LW),
        .HASH_W      (HW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_addr_i      (req_addr),
        .req_len_i       (req_len),
        .req_ready_o     (req_ready),
        .eng_clr_o       (eng_clr),
        .eng_start_o     (eng_start),
        .eng_base_addr_o (eng_base_addr),
        .eng_num_bytes_o (eng_num_bytes),
        .eng_out_ready_i (eng_out_ready),
        .eng_hash_i      (eng_hash),
        .rsp_valid_o     (rsp_valid),
        .rsp_id_o        (rsp_id),
        .rsp_hash_o      (rsp_hash),
        .rsp_err_o       (rsp_err),
        .rsp_ready_i     (rsp_ready),
        .busy_o          (busy),
        .jobs_done_o     (jobs_done)
    );

    task automatic check(input string tag, input logic [HW-1:0] act, input logic [HW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_valid[i]          = v;
        req_addr[i*AW +: AW]  = a;
        req_len[i*LW +: LW]   = l;
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_jobs++;
        check({tag, "_jobs"}, HW'(jobs_done), HW'(exp_jobs));
        check({tag, "_rspv_lo"}, HW'(rsp_valid), HW'(0));
    endtask

    // Full engine-backed job: waits for the grant, answers with hash, optionally stalls the response.
    task automatic serve(input string tag, input int exp_id, input logic [LW-1:0] exp_len,
                         input logic [HW-1:0] hash, input int hold, input logic drop);
        logic [N-1:0] exp_rdy;
        int n;
        exp_rdy = N'(1) << exp_id;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, HW'(req_ready), HW'(exp_rdy));
        check({tag, "_clr"}, HW'(eng_clr), HW'(1));
        check({tag, "_len"}, HW'(eng_num_bytes), HW'(exp_len));
        if (drop) req_valid[exp_id] = 1'b0;
        tick();
        check({tag, "_start"}, HW'(eng_start), HW'(1));
        tick();
        eng_out_ready = 1'b1;
        eng_hash      = hash;
        tick();
        eng_out_ready = 1'b0;
        check({tag, "_rspv"}, HW'(rsp_valid), HW'(1));
        check({tag, "_id"}, HW'(rsp_id), HW'(exp_id));
        check({tag, "_hash"}, rsp_hash, hash);
        check({tag, "_err"}, HW'(rsp_err), HW'(0));
        for (int c = 0; c < hold; c++) begin
            tick();
            check({tag, "_hold_v"}, HW'(rsp_valid), HW'(1));
            check({tag, "_hold_hash"}, rsp_hash, hash);
            check({tag, "_hold_rdy"}, HW'(req_ready), HW'(0));
            check({tag, "_hold_jobs"}, HW'(jobs_done), HW'(exp_jobs));
        end
        handshake(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, HW'(req_ready), HW'(0));
        check({tag, "_clr"}, HW'(eng_clr), HW'(0));
        check({tag, "_start"}, HW'(eng_start), HW'(0));
        check({tag, "_base"}, HW'(eng_base_addr), HW'(0));
        check({tag, "_nbytes"}, HW'(eng_num_bytes), HW'(0));
        check({tag, "_rspv"}, HW'(rsp_valid), HW'(0));
        check({tag, "_id"}, HW'(rsp_id), HW'(0));
        check({tag, "_hash"}, rsp_hash, HW'(0));
        check({tag, "_err"}, HW'(rsp_err), HW'(0));
        check({tag, "_busy"}, HW'(busy), HW'(0));
        check({tag, "_jobs"}, HW'(jobs_done), HW'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [HW-1:0] h;
        int n;
        reset         = 1'b1;
        req_valid     = '0;
        req_addr      = '0;
        req_len       = '0;
        eng_out_ready = 1'b0;
        eng_hash      = '0;
        rsp_ready     = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single job with exact cycle latencies
        set_req(0, 1'b1, 32'h10, 16'd200);
        tick();
        check("single_arb_busy", HW'(busy), HW'(1));
        check("single_arb_rdy", HW'(req_ready), HW'(0));
        tick();
        check("single_rdy", HW'(req_ready), HW'(4'b0001));
        check("single_clr", HW'(eng_clr), HW'(1));
        check("single_base", HW'(eng_base_addr), HW'(32'h10));
        check("single_len", HW'(eng_num_bytes), HW'(200));
        check("single_nostart", HW'(eng_start), HW'(0));
        req_valid[0] = 1'b0;
        tick();
        check("single_start", HW'(eng_start), HW'(1));
        check("single_clr_lo", HW'(eng_clr), HW'(0));
        check("single_rdy_lo", HW'(req_ready), HW'(0));
        tick();
        check("single_start_lo", HW'(eng_start), HW'(0));
        eng_out_ready = 1'b1;
        eng_hash      = {64{8'hAB}};
        tick();
        eng_out_ready = 1'b0;
        check("single_rspv", HW'(rsp_valid), HW'(1));
        check("single_id", HW'(rsp_id), HW'(0));
        check("single_hash", rsp_hash, {64{8'hAB}});
        check("single_err", HW'(rsp_err), HW'(0));
        check("single_base_hold", HW'(eng_base_addr), HW'(32'h10));
        handshake("single");
        check("single_idle", HW'(busy), HW'(0));

        // Zero-length job: response two cycles after request, engine untouched
        set_req(2, 1'b1, 32'h40, 16'd0);
        tick();
        check("zero_arb_rspv", HW'(rsp_valid), HW'(0));
        tick();
        check("zero_rspv", HW'(rsp_valid), HW'(1));
        check("zero_rdy", HW'(req_ready), HW'(4'b0100));
        check("zero_clr", HW'(eng_clr), HW'(0));
        check("zero_err", HW'(rsp_err), HW'(1));
        check("zero_hash", rsp_hash, HW'(0));
        check("zero_id", HW'(rsp_id), HW'(2));
        req_valid[2] = 1'b0;
        tick();
        check("zero_start", HW'(eng_start), HW'(0));
        check("zero_clr2", HW'(eng_clr), HW'(0));
        handshake("zero");

        // Timeout: engine stays silent, abort exactly TMO cycles after entering WAIT
        set_req(3, 1'b1, 32'h80, 16'd64);
        tick();
        tick();
        check("tmo_rdy", HW'(req_ready), HW'(4'b1000));
        req_valid[3] = 1'b0;
        tick();
        check("tmo_start", HW'(eng_start), HW'(1));
        tick();
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("tmo_latency", HW'(n), HW'(TMO));
        check("tmo_err", HW'(rsp_err), HW'(1));
        check("tmo_hash", rsp_hash, HW'(0));
        check("tmo_id", HW'(rsp_id), HW'(3));
        handshake("tmo");

        set_req(1, 1'b1, 32'h100, 16'd32);
        serve("post_tmo", 1, 16'd32, {16{32'hC0DE_0001}}, 0, 1'b1);

        // Backpressure with a competing requester pending
        set_req(2, 1'b1, 32'h200, 16'd1000);
        set_req(0, 1'b1, 32'h300, 16'd8);
        serve("bp", 2, 16'd1000, {64{8'h5A}}, 20, 1'b1);
        serve("after_bp", 0, 16'd8, {16{32'h1234_5678}}, 0, 1'b1);

        // Reset in the middle of WAIT
        set_req(1, 1'b1, 32'h400, 16'd16);
        tick();
        tick();
        req_valid[1] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        exp_jobs = 0;
        check_all_zero("midrst");
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("midrst_norsp", HW'(rsp_valid), HW'(0));

        // Fairness: rr_ptr restarts at 0 after reset
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(32'h1000 * (i + 1)), LW'(16 * (i + 1)));
        for (int j = 0; j < 8; j++) begin
            h = {16{32'(j + 1)}};
            serve($sformatf("fair%0d", j), j % N, LW'(16 * ((j % N) + 1)), h, 0, 1'b0);
        end
        req_valid = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
